// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - shared types and constants for the divide unit
package instruction_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      DIV_OP  = 2'b00,
      DIVU_OP = 2'b01,
      REM_OP  = 2'b10,
      REMU_OP = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_e;

   localparam logic [XLEN-1:0] DIV_SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
   import instruction_pkg::*;
(
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] divisor,
   input  logic            next_bit,
   output logic [XLEN:0]   rem_next,
   output logic            q_bit
);

   logic [XLEN+1:0] shifted;

   // The compare runs at full width so the subtract below never needs the top bit.
   assign shifted  = {rem, next_bit};
   assign q_bit    = (shifted >= {2'b00, divisor});
   assign rem_next = shifted[XLEN:0] - (q_bit ? {1'b0, divisor} : {(XLEN+1){1'b0}});

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 divider for DIV/DIVU/REM/REMU
module div_unit
   import instruction_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            div_start,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] div_a,
   input  logic [XLEN-1:0] div_b,
   input  logic            div_kill,
   output logic            div_busy,
   output logic            div_wb,
   output logic [XLEN-1:0] div_result
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN:0]    rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvsr_q, dvsr_d;
   logic [XLEN-1:0]  res_q, res_d;
   div_op_e          op_q, op_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;

   logic [XLEN:0]    step_rem;
   logic             step_bit;

   // The quotient register doubles as the dividend shifter: its MSB feeds each step.
   div_step u_step (
      .rem      (rem_q),
      .divisor  (dvsr_q),
      .next_bit (quo_q[XLEN-1]),
      .rem_next (step_rem),
      .q_bit    (step_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         res_q    <= '0;
         op_q     <= DIV_OP;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         res_q    <= res_d;
         op_q     <= op_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
      end
   end

   always_comb begin
      logic            signed_op;
      logic            a_neg;
      logic            b_neg;
      logic [XLEN-1:0] abs_a;
      logic [XLEN-1:0] abs_b;
      logic [XLEN-1:0] q_fix;
      logic [XLEN-1:0] r_fix;

      state_d  = state_q;
      count_d  = count_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      res_d    = res_q;
      op_d     = op_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;

      signed_op = ~div_op[0];
      a_neg     = signed_op & div_a[XLEN-1];
      b_neg     = signed_op & div_b[XLEN-1];
      abs_a     = a_neg ? -div_a : div_a;
      abs_b     = b_neg ? -div_b : div_b;
      q_fix     = sign_q_q ? -quo_q : quo_q;
      r_fix     = sign_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

      case (state_q)
         IDLE: begin
            if (div_start && !div_kill) begin
               op_d     = div_op_e'(div_op);
               dvsr_d   = abs_b;
               quo_d    = abs_a;
               rem_d    = '0;
               count_d  = CNT_W'(XLEN-1);
               sign_q_d = a_neg ^ b_neg;
               sign_r_d = a_neg;
               if (div_b == '0) begin
                  res_d   = div_op[1] ? div_a : '1;
                  state_d = DONE;
               end else if (signed_op && div_a == DIV_SIGNED_MIN && div_b == '1) begin
                  res_d   = div_op[1] ? '0 : DIV_SIGNED_MIN;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d   = step_rem;
            quo_d   = {quo_q[XLEN-2:0], step_bit};
            count_d = count_q - CNT_W'(1);
            if (count_q == '0) state_d = FIX;
         end
         FIX: begin
            res_d   = op_q[1] ? r_fix : q_fix;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (div_kill) state_d = IDLE;
   end

   // Kill must be able to cancel a write-back in the DONE cycle itself, so it gates it directly.
   assign div_busy   = (state_q != IDLE);
   assign div_wb     = (state_q == DONE) && !div_kill;
   assign div_result = div_wb ? res_q : '0;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

   logic        clk;
   logic        reset_n;
   logic        div_start;
   logic [1:0]  div_op;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_kill;
   logic        div_busy;
   logic        div_wb;
   logic [31:0] div_result;

   int errors = 0;
   int checks = 0;

   div_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .div_start  (div_start),
      .div_op     (div_op),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_kill   (div_kill),
      .div_busy   (div_busy),
      .div_wb     (div_wb),
      .div_result (div_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Launches one operation and reports when write-back came, its value and busy behaviour.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int wb_cyc, output logic [31:0] res, output bit busy_ok);
      int cyc;
      next_cycle();
      div_op = op; div_a = a; div_b = b; div_start = 1'b1;
      next_cycle();
      div_start = 1'b0;
      cyc = 1; wb_cyc = -1; busy_ok = 1'b1; res = '0;
      while (cyc < 60 && wb_cyc < 0) begin
         if (div_busy !== 1'b1) busy_ok = 1'b0;
         if (div_wb === 1'b1) begin
            wb_cyc = cyc;
            res = div_result;
         end else begin
            next_cycle();
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; div_start = 0; div_op = 0; div_a = 0; div_b = 0; div_kill = 0;
      repeat (2) next_cycle();
      checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
      checks++; if (div_wb !== 1'b0) begin errors++; $display("FAIL reset_wb got=%b exp=0", div_wb); end
      checks++; if (div_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", div_result); end
      reset_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_unsigned();
      int wc; logic [31:0] r; bit bok;
      do_op(2'b01, 32'd100, 32'd7, wc, r, bok);
      checks++; if (wc !== 34) begin errors++; $display("FAIL divu_wb_cycle got=%0d exp=34", wc); end
      checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result got=%h exp=%h", r, 32'd14); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL divu_busy got=%b exp=1", bok); end
      next_cycle();
      checks++; if (div_wb !== 1'b0 || div_busy !== 1'b0 || div_result !== 32'h0)
         begin errors++; $display("FAIL divu_after got=wb%b busy%b res%h exp=0/0/0", div_wb, div_busy, div_result); end
      do_op(2'b11, 32'd100, 32'd7, wc, r, bok);
      checks++; if (r !== 32'd2 || wc !== 34) begin errors++; $display("FAIL remu_result got=%h@%0d exp=2@34", r, wc); end
      do_op(2'b01, 32'hFFFF_FFF9, 32'd2, wc, r, bok);
      checks++; if (r !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big got=%h exp=7ffffffc", r); end
   endtask

   task automatic test_signed();
      int wc; logic [31:0] r; bit bok;
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, wc, r, bok);
      checks++; if (r !== 32'hFFFF_FFFD || wc !== 34) begin errors++; $display("FAIL div_neg got=%h@%0d exp=fffffffd@34", r, wc); end
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, wc, r, bok);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
      do_op(2'b00, 32'd100, 32'hFFFF_FFF9, wc, r, bok);
      checks++; if (r !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_negb got=%h exp=fffffff2", r); end
   endtask

   task automatic test_special();
      int wc; logic [31:0] r; bit bok;
      do_op(2'b01, 32'd5, 32'd0, wc, r, bok);
      checks++; if (r !== 32'hFFFF_FFFF || wc !== 1) begin errors++; $display("FAIL divu_zero got=%h@%0d exp=ffffffff@1", r, wc); end
      do_op(2'b11, 32'd5, 32'd0, wc, r, bok);
      checks++; if (r !== 32'd5 || wc !== 1) begin errors++; $display("FAIL remu_zero got=%h@%0d exp=5@1", r, wc); end
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, wc, r, bok);
      checks++; if (r !== 32'h8000_0000 || wc !== 1) begin errors++; $display("FAIL div_ovf got=%h@%0d exp=80000000@1", r, wc); end
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, wc, r, bok);
      checks++; if (r !== 32'h0 || wc !== 1) begin errors++; $display("FAIL rem_ovf got=%h@%0d exp=0@1", r, wc); end
   endtask

   task automatic test_kill();
      int cyc; int wb_cyc; int early_wb; logic [31:0] r;
      next_cycle();
      div_op = 2'b01; div_a = 32'd100; div_b = 32'd7; div_start = 1'b1;
      early_wb = 0;
      for (cyc = 1; cyc <= 10; cyc++) begin
         next_cycle();
         div_start = (cyc == 5);
         if (cyc == 5) div_a = 32'd50;
         if (div_wb === 1'b1) early_wb++;
         div_kill = (cyc == 10);
      end
      next_cycle();
      div_kill = 1'b0;
      checks++; if (div_busy !== 1'b0 || div_wb !== 1'b0 || early_wb != 0)
         begin errors++; $display("FAIL kill_idle got=busy%b wb%b early%0d exp=0/0/0", div_busy, div_wb, early_wb); end
      div_a = 32'd100; div_start = 1'b1;
      wb_cyc = -1; r = '0;
      for (cyc = 12; cyc < 70 && wb_cyc < 0; cyc++) begin
         next_cycle();
         div_start = (cyc == 20);
         if (cyc == 20) div_a = 32'd1000;
         if (div_wb === 1'b1) begin wb_cyc = cyc; r = div_result; end
      end
      div_start = 1'b0;
      checks++; if (wb_cyc !== 45 || r !== 32'd14) begin errors++; $display("FAIL kill_restart got=%h@%0d exp=e@45", r, wb_cyc); end
      next_cycle();
      div_op = 2'b01; div_a = 32'd9; div_b = 32'd3; div_start = 1'b1; div_kill = 1'b1;
      next_cycle();
      div_start = 1'b0; div_kill = 1'b0;
      checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL kill_start_same got=%b exp=0", div_busy); end
   endtask

   task automatic test_reset_mid();
      int seen;
      next_cycle();
      div_op = 2'b01; div_a = 32'd100; div_b = 32'd7; div_start = 1'b1;
      next_cycle();
      div_start = 1'b0;
      repeat (19) next_cycle();
      #2 reset_n = 1'b0;
      #1;
      checks++; if (div_busy !== 1'b0 || div_wb !== 1'b0 || div_result !== 32'h0)
         begin errors++; $display("FAIL reset_mid got=busy%b wb%b res%h exp=0/0/0", div_busy, div_wb, div_result); end
      repeat (2) next_cycle();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         if (div_wb === 1'b1 || div_busy === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL reset_no_wb got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_kill();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
